bcd_stopwatch: RTL and testbench

//   Parametrised decimal stopwatch for the 7-segment display path. Counts ticks of
//   a prescaled clock into NUM_DIGITS BCD digits, supports start/pause and clear, and

---
 rtl/bcd_stopwatch_if.sv | 37 +++
 rtl/bcd_stopwatch.sv | 147 ++++++++++++++
 tb/tb_bcd_stopwatch.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_if.sv
// Signal bundle between the stopwatch and its display/button side.
// Carries the lap input only when STOPWATCH_LAP_EN is defined.
interface bcd_stopwatch_if #(
  parameter int NUM_DIGITS = 2
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    start_stop;
  logic                    clear;
  logic [SEL_W-1:0]        digit_sel;
  logic [3:0]              num;
  logic [4*NUM_DIGITS-1:0] bcd_all;
  logic                    running;
  logic                    tick;
  logic                    wrap;
`ifdef STOPWATCH_LAP_EN
  logic                    lap;

  modport master (
    output start_stop, clear, digit_sel, lap,
    input  num, bcd_all, running, tick, wrap
  );
  modport slave (
    input  start_stop, clear, digit_sel, lap,
    output num, bcd_all, running, tick, wrap
  );
`else
  modport master (
    output start_stop, clear, digit_sel,
    input  num, bcd_all, running, tick, wrap
  );
  modport slave (
    input  start_stop, clear, digit_sel,
    output num, bcd_all, running, tick, wrap
  );
`endif
endinterface

// File: rtl/bcd_stopwatch.sv
// Prescaled BCD stopwatch with start/pause, clear and wrap at MAX_VAL.
// Optional lap freeze of the displayed digits when STOPWATCH_LAP_EN is defined.
module bcd_stopwatch #(
  parameter int CLK_DIV    = 20_000_000,
  parameter int NUM_DIGITS = 2,
  parameter int MAX_VAL    = 32
) (
  input  logic           clk,
  input  logic           rst,
  bcd_stopwatch_if.slave sw
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int CNT_W = (MAX_VAL > 0) ? $clog2(MAX_VAL + 1) : 1;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  logic             run_q, run_d;
  logic             ss_prev_q, ss_prev_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digits_t          dig_q, dig_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             ss_rise, inc, at_max;
  digits_t          view;

  // Ripple-carry increment: a 9 rolls to 0 and passes the carry upward.
  function automatic digits_t bcd_inc(input digits_t d);
    digits_t r;
    logic    carry;
    r     = d;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (r[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = r[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    ss_rise   = sw.start_stop & ~ss_prev_q;
    inc       = run_q && (pre_q == PRE_W'(CLK_DIV - 1));
    at_max    = (cnt_q == CNT_W'(MAX_VAL));
    ss_prev_d = sw.start_stop;
    run_d     = run_q ^ ss_rise;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    if (sw.clear) begin
      pre_d = '0;
      cnt_d = '0;
      dig_d = '0;
    end else begin
      if (run_q) pre_d = inc ? '0 : pre_q + 1'b1;
      if (inc) begin
        tick_d = 1'b1;
        if (at_max) begin
          cnt_d  = '0;
          dig_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          dig_d = bcd_inc(dig_q);
        end
      end
    end
  end

  // Stage boundary: count, control and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= 1'b0;
      ss_prev_q <= 1'b0;
      pre_q     <= '0;
      cnt_q     <= '0;
      dig_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      run_q     <= run_d;
      ss_prev_q <= ss_prev_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic    lap_prev_q, lap_prev_d;
  logic    freeze_q, freeze_d;
  logic    lap_rise;
  digits_t lap_q, lap_d;

  always_comb begin
    lap_rise   = sw.lap & ~lap_prev_q;
    lap_prev_d = sw.lap;
    freeze_d   = freeze_q;
    lap_d      = lap_q;
    if (sw.clear) begin
      freeze_d = 1'b0;
    end else if (lap_rise) begin
      freeze_d = ~freeze_q;
      if (!freeze_q) lap_d = dig_q;
    end
  end

  // Stage boundary: lap capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_prev_q <= 1'b0;
      freeze_q   <= 1'b0;
      lap_q      <= '0;
    end else begin
      lap_prev_q <= lap_prev_d;
      freeze_q   <= freeze_d;
      lap_q      <= lap_d;
    end
  end

  assign view = freeze_q ? lap_q : dig_q;
`else
  assign view = dig_q;
`endif

  always_comb begin
    sw.num = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sw.digit_sel == SEL_W'(i)) sw.num = view[i];
    end
  end

  assign sw.bcd_all = view;
  assign sw.running = run_q;
  assign sw.tick    = tick_q;
  assign sw.wrap    = wrap_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: tick scoreboard plus cycle-exact checks.
module tb_bcd_stopwatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   tick_seen = 0;
  int   last_cyc = 0;
  bit   have_last = 1'b0;
  bit   period_chk = 1'b0;
  int   m = 0;
  bit   frozen = 1'b0;
  logic [7:0] lap_disp = 8'h00;
  int   ts;

  typedef struct packed {
    logic [7:0] bcd;
    logic       wrap;
  } exp_t;
  exp_t q[$];

  bcd_stopwatch_if #(.NUM_DIGITS(2)) sw ();
  bcd_stopwatch_if #(.NUM_DIGITS(3)) sw3 ();

  bcd_stopwatch #(.CLK_DIV(4), .NUM_DIGITS(2), .MAX_VAL(32)) dut (
    .clk(clk), .rst(rst), .sw(sw)
  );
  bcd_stopwatch #(.CLK_DIV(2), .NUM_DIGITS(3), .MAX_VAL(999)) dut3 (
    .clk(clk), .rst(rst), .sw(sw3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd2(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Model of one count increment; pushes what the display should show with its tick.
  task automatic push_n(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.wrap = (m == 32);
      m      = e.wrap ? 0 : m + 1;
      e.bcd  = frozen ? lap_disp : to_bcd2(m);
      q.push_back(e);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", q.size(), 0);
  endtask

  task automatic wait_tick(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sw.tick && n < max_cyc);
    check("wait_tick", sw.tick, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sw.wrap) check("wrap_with_tick", sw.tick, 1);
      if (sw.tick) begin
        tick_seen++;
        check("tick_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("tick_bcd", sw.bcd_all, e.bcd);
          check("tick_wrap", sw.wrap, e.wrap);
        end
        if (period_chk && have_last) check("tick_period", cyc - last_cyc, 4);
        if (period_chk) begin
          last_cyc  = cyc;
          have_last = 1'b1;
        end
      end
      if (!period_chk) have_last = 1'b0;
    end
  end

  initial begin
    sw.start_stop  = 1'b0;
    sw.clear       = 1'b0;
    sw.digit_sel   = '0;
    sw3.start_stop = 1'b0;
    sw3.clear      = 1'b0;
    sw3.digit_sel  = '0;
`ifdef STOPWATCH_LAP_EN
    sw.lap  = 1'b0;
    sw3.lap = 1'b0;
`endif
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_bcd", sw.bcd_all, 8'h00);
    check("rst_running", sw.running, 0);
    check("rst_tick", sw.tick, 0);
    check("rst_wrap", sw.wrap, 0);
    check("rst_num", sw.num, 4'h0);
    repeat (50) @(posedge clk);
    #1;
    check("idle_ticks", tick_seen, 0);
    check("idle_running", sw.running, 0);

    // Start with a held button, count 01..10
    period_chk = 1'b1;
    sw.start_stop = 1'b1;
    push_n(10);
    repeat (20) @(posedge clk);
    #1;
    check("held_running", sw.running, 1);
    sw.start_stop = 1'b0;
    drain(100);
    check("count_10", sw.bcd_all, 8'h10);

    // Run to 32, wrap to 00, then 01
    push_n(24);
    drain(120);

    // Pause with the prescaler at 2
    push_n(1);
    wait_tick(10);
    period_chk = 1'b0;
    @(posedge clk);
    #1 sw.start_stop = 1'b1;
    @(posedge clk);
    #1 sw.start_stop = 1'b0;
    check("pause_running", sw.running, 0);
    ts = tick_seen;
    repeat (10) @(posedge clk);
    #1;
    check("pause_running_hold", sw.running, 0);
    check("pause_bcd_hold", sw.bcd_all, 8'h02);
    check("pause_no_tick", tick_seen, ts);
    push_n(1);
    sw.start_stop = 1'b1;
    @(posedge clk);
    #1 sw.start_stop = 1'b0;
    check("resume_running", sw.running, 1);
    check("resume_tick_c1", sw.tick, 0);
    @(posedge clk);
    #1 check("resume_tick_c2", sw.tick, 0);
    @(posedge clk);
    #1 check("resume_tick_c3", sw.tick, 1);
    check("resume_bcd", sw.bcd_all, 8'h03);

    // Clear on the increment-strobe cycle
    push_n(1);
    wait_tick(10);
    repeat (3) @(posedge clk);
    #1 sw.clear = 1'b1;
    @(posedge clk);
    #1 sw.clear = 1'b0;
    m = 0;
    check("clear_bcd", sw.bcd_all, 8'h00);
    check("clear_no_tick", sw.tick, 0);
    check("clear_running", sw.running, 1);
    push_n(1);
    repeat (3) @(posedge clk);
    #1 check("clear_next_c3", sw.tick, 0);
    @(posedge clk);
    #1 check("clear_next_c4", sw.tick, 1);
    check("clear_next_bcd", sw.bcd_all, 8'h01);
    sw.digit_sel = 1'b0;
    #1 check("num_sel0", sw.num, 4'h1);
    sw.digit_sel = 1'b1;
    #1 check("num_sel1", sw.num, 4'h0);
    sw.digit_sel = 1'b0;
    @(negedge clk);
    period_chk = 1'b1;

    // start_stop rise on the strobe cycle: increment taken, then stop
    push_n(1);
    wait_tick(10);
    push_n(1);
    repeat (3) @(posedge clk);
    #1 sw.start_stop = 1'b1;
    @(posedge clk);
    #1 sw.start_stop = 1'b0;
    check("edge_strobe_tick", sw.tick, 1);
    check("edge_strobe_bcd", sw.bcd_all, 8'h03);
    check("edge_strobe_running", sw.running, 0);
    period_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("stopped_running", sw.running, 0);
    push_n(4);
    sw.start_stop = 1'b1;
    @(posedge clk);
    #1 sw.start_stop = 1'b0;
    drain(40);
    check("count_07", sw.bcd_all, 8'h07);

`ifdef STOPWATCH_LAP_EN
    // Lap freeze at 07 while the live count runs to 12
    sw.lap = 1'b1;
    @(posedge clk);
    #1 sw.lap = 1'b0;
    frozen   = 1'b1;
    lap_disp = 8'h07;
    sw.digit_sel = 1'b0;
    #1 check("lap_num0", sw.num, 4'h7);
    sw.digit_sel = 1'b1;
    #1 check("lap_num1", sw.num, 4'h0);
    push_n(5);
    drain(40);
    check("lap_frozen_bcd", sw.bcd_all, 8'h07);
    sw.lap = 1'b1;
    @(posedge clk);
    #1 sw.lap = 1'b0;
    frozen = 1'b0;
    sw.digit_sel = 1'b0;
    #1 check("live_num0", sw.num, 4'h2);
    sw.digit_sel = 1'b1;
    #1 check("live_num1", sw.num, 4'h1);
    check("live_bcd", sw.bcd_all, to_bcd2(m));
    sw.digit_sel = 1'b0;
`endif

    // Stop the main instance
    sw.start_stop = 1'b1;
    @(posedge clk);
    #1 sw.start_stop = 1'b0;
    check("final_stop", sw.running, 0);

    // Three-digit instance: 23 ticks and out-of-range digit_sel
    sw3.start_stop = 1'b1;
    repeat (47) @(posedge clk);
    #1;
    check("d3_bcd", sw3.bcd_all, 12'h023);
    sw3.digit_sel = 2'd0;
    #1 check("d3_num0", sw3.num, 4'h3);
    sw3.digit_sel = 2'd1;
    #1 check("d3_num1", sw3.num, 4'h2);
    sw3.digit_sel = 2'd2;
    #1 check("d3_num2", sw3.num, 4'h0);
    sw3.digit_sel = 2'd3;
    #1 check("d3_num_oor", sw3.num, 4'hF);
    sw3.start_stop = 1'b0;

    // Reset while the three-digit instance is running
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_bcd", sw.bcd_all, 8'h00);
    check("rst2_d3_bcd", sw3.bcd_all, 12'h000);
    check("rst2_d3_running", sw3.running, 0);
    check("rst2_tick", sw3.tick, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
